// File: rtl/mem_uploader.sv
// Reads a contiguous RAM region through a 1-cycle-latency read port and streams it
// out one byte per valid/ready handshake, tagged with the byte offset and region index.
module mem_uploader #(
  parameter int ADDR_W = 14,
  parameter int OUT_AW = 17
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic              up_start,
  input  logic [7:0]        up_index_in,
  input  logic [ADDR_W-1:0] up_base,
  input  logic [ADDR_W:0]   up_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        up_index,
  output logic [OUT_AW-1:0] up_addr,
  output logic [7:0]        up_data,
  output logic              up_valid,
  input  logic              up_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_index;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_offset;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic [OUT_AW-1:0] r_up_addr;
  logic [7:0]        r_up_data;
  logic              r_up_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_hs;
  logic [ADDR_W:0]   w_off_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_fetch_addr;

  assign w_hs      = r_up_valid && up_ready;
  assign w_off_inc = r_offset + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last    = (w_off_inc == r_len);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (up_start) begin
          if (up_len == {(ADDR_W+1){1'b0}}) begin
            w_next = S_DONE;
          end else begin
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          w_next = w_last ? S_DONE : S_FETCH;
        end else begin
          w_next = S_SEND;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address for the next FETCH: the first one comes straight from the start inputs
  always_comb begin
    w_fetch_addr = {ADDR_W{1'b0}};
    if (r_state == S_IDLE) begin
      w_fetch_addr = up_base;
    end else begin
      w_fetch_addr = r_base + w_off_inc[ADDR_W-1:0];
    end
  end

  // State, transfer context and registered outputs
  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_index    <= 8'd0;
      r_base     <= {ADDR_W{1'b0}};
      r_len      <= {(ADDR_W+1){1'b0}};
      r_offset   <= {(ADDR_W+1){1'b0}};
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mem_rd   <= 1'b0;
      r_up_addr  <= {OUT_AW{1'b0}};
      r_up_data  <= 8'd0;
      r_up_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (up_start) begin
            r_index  <= up_index_in;
            r_base   <= up_base;
            r_len    <= up_len;
            r_offset <= {(ADDR_W+1){1'b0}};
          end
        end
        S_LATCH: begin
          r_up_data <= mem_data;
          r_up_addr <= OUT_AW'(r_offset);
        end
        S_SEND: begin
          if (w_hs) begin
            r_offset <= w_off_inc;
          end
        end
        default: begin
          r_offset <= r_offset;
        end
      endcase
      if (w_next == S_FETCH) begin
        r_mem_addr <= w_fetch_addr;
      end
      r_mem_rd   <= (w_next == S_FETCH);
      r_up_valid <= (w_next == S_SEND);
      // busy stays up through the done pulse and falls the cycle after it
      r_busy     <= (w_next != S_IDLE) || (r_state == S_DONE);
      r_done     <= (r_state == S_DONE);
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign up_index = r_index;
  assign up_addr  = r_up_addr;
  assign up_data  = r_up_data;
  assign up_valid = r_up_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
